// File: rtl/lu_pkg.sv
// Shared definitions for the pipelined logic unit: op codes and the bitwise evaluator.
// lu_eval works on LU_MAX_W-bit vectors; callers zero-extend operands and truncate the result.
package lu_pkg;

    localparam int unsigned LU_MAX_W = 64;

    typedef enum logic [2:0] {
        LU_AND  = 3'd0,
        LU_OR   = 3'd1,
        LU_NAND = 3'd2,
        LU_NOR  = 3'd3,
        LU_XOR  = 3'd4,
        LU_XNOR = 3'd5,
        LU_NOTA = 3'd6,
        LU_PASS = 3'd7
    } lu_op_t;

    function automatic logic [LU_MAX_W-1:0] lu_eval(
        input logic [LU_MAX_W-1:0] a,
        input logic [LU_MAX_W-1:0] b,
        input lu_op_t              op
    );
        logic [LU_MAX_W-1:0] res;
        case (op)
            LU_AND:  res = a & b;
            LU_OR:   res = a | b;
            LU_NAND: res = ~(a & b);
            LU_NOR:  res = ~(a | b);
            LU_XOR:  res = a ^ b;
            LU_XNOR: res = ~(a ^ b);
            LU_NOTA: res = ~a;
            default: res = a;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lu_pipe_stage.sv
// One elastic register stage: loads when empty or when downstream drains it.
// Data only updates on a valid beat, so a held or bubbled stage keeps its last value.
module lu_pipe_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_adv;

    assign w_adv   = !r_valid || i_ready;
    assign o_ready = w_adv;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_adv) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined WIDTH-bit logic unit (WIDTH <= 64) with valid/ready on both sides.
// Define LOGIC_UNIT_FLAGS_EN to register zero/parity flags alongside y; otherwise they are tied to 0.
module logic_unit_pipe
    import lu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity
);

    localparam int unsigned S1_W = 3 + 2 * WIDTH;
`ifdef LOGIC_UNIT_FLAGS_EN
    localparam int unsigned S2_W = WIDTH + 2;
`else
    localparam int unsigned S2_W = WIDTH;
`endif

    logic                w_s1_valid;
    logic                w_s2_ready;
    logic [S1_W-1:0]     w_s1_data;
    logic [S2_W-1:0]     w_s2_in;
    logic [S2_W-1:0]     w_s2_data;
    logic [WIDTH-1:0]    w_s1_a;
    logic [WIDTH-1:0]    w_s1_b;
    lu_op_t              w_s1_op;
    logic [LU_MAX_W-1:0] w_a_ext;
    logic [LU_MAX_W-1:0] w_b_ext;
    logic [LU_MAX_W-1:0] w_eval;
    logic [WIDTH-1:0]    w_res;

    lu_pipe_stage #(.W(S1_W)) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  ({op, a, b}),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready),
        .o_data  (w_s1_data)
    );

    assign w_s1_op = lu_op_t'(w_s1_data[S1_W-1 -: 3]);
    assign w_s1_a  = w_s1_data[2*WIDTH-1:WIDTH];
    assign w_s1_b  = w_s1_data[WIDTH-1:0];

    always_comb begin
        w_a_ext              = '0;
        w_b_ext              = '0;
        w_a_ext[WIDTH-1:0]   = w_s1_a;
        w_b_ext[WIDTH-1:0]   = w_s1_b;
    end

    assign w_eval = lu_eval(w_a_ext, w_b_ext, w_s1_op);
    assign w_res  = w_eval[WIDTH-1:0];

`ifdef LOGIC_UNIT_FLAGS_EN
    // Store "non-zero" rather than "zero" so the reset-cleared register reads zero = 1 with y = 0.
    assign w_s2_in = {w_res, |w_res, ^w_res};
    assign y       = w_s2_data[WIDTH+1:2];
    assign zero    = ~w_s2_data[1];
    assign parity  = w_s2_data[0];
`else
    assign w_s2_in = w_res;
    assign y       = w_s2_data;
    assign zero    = 1'b0;
    assign parity  = 1'b0;
`endif

    lu_pipe_stage #(.W(S2_W)) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_data  (w_s2_in),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_s2_data)
    );

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and random-handshake bench for logic_unit_pipe (WIDTH = 8).
// Flag expectations follow LOGIC_UNIT_FLAGS_EN when the bench is built with it.
module tb_logic_unit_pipe;
    import lu_pkg::*;

`ifdef LOGIC_UNIT_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       zero;
    logic       parity;

    int n_vec = 0;
    int n_bad = 0;

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .parity    (parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Streams a=F0, b=CC with op 0..7; out_ready low for stall_len cycles from stall_start.
    task automatic run_stream(input int stall_start, input int stall_len);
        logic [7:0] exp_tab [8];
        int acc_cyc [8];
        int n_in  = 0;
        int n_out = 0;
        int cyc   = 0;
        bit stalled;
        exp_tab = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
        while (n_out < 8 && cyc < 40) begin
            @(posedge clk); #1;
            stalled   = (cyc >= stall_start) && (cyc < stall_start + stall_len);
            in_valid  = (n_in < 8);
            a         = 8'hF0;
            b         = 8'hCC;
            op        = 3'(n_in);
            out_ready = !stalled;
            @(negedge clk);
            if (stalled) begin
                if (cyc == stall_start) check("bp_accepted", n_in, 2);
                check("bp_in_ready", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                check("bp_y_hold", y, 8'hC0);
            end
            if (out_valid && out_ready) begin
                check("stream_y", y, exp_tab[n_out]);
                if (stall_len == 0) check("stream_latency", cyc - acc_cyc[n_out], 2);
                n_out++;
            end
            if (in_valid && in_ready) begin
                acc_cyc[n_in] = cyc;
                n_in++;
            end
            cyc++;
        end
        check("stream_count", n_out, 8);
        check("stream_in_count", n_in, 8);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic run_random(input int beats);
        logic [7:0] q [$];
        int n_in  = 0;
        int n_out = 0;
        int cyc   = 0;
        logic       hold = 1'b0;
        logic [7:0] prev_y = '0;
        while (n_out < beats && cyc < 20000) begin
            @(posedge clk); #1;
            in_valid  = (n_in < beats) && ($urandom_range(1) == 1);
            a         = 8'($urandom);
            b         = 8'($urandom);
            op        = 3'($urandom);
            out_ready = ($urandom_range(1) == 1);
            @(negedge clk);
            if (hold) check("rand_hold", {out_valid, y}, {1'b1, prev_y});
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("rand_outstanding", q.size(), 1);
                else               check("rand_y", y, q.pop_front());
                n_out++;
            end
            hold   = out_valid && !out_ready;
            prev_y = y;
            if (in_valid && in_ready) begin
                q.push_back(8'(lu_eval(64'(a), 64'(b), lu_op_t'(op))));
                n_in++;
            end
            cyc++;
        end
        check("rand_count", n_out, beats);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic send_one(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                            input logic [2:0] top, input logic [7:0] ey,
                            input logic ez, input logic ep);
        int n = 0;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        op        = top;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_y"}, y, ey);
        check({tag, "_zero"}, zero, ez);
        check({tag, "_parity"}, parity, ep);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_y", y, 8'h00);
        check("rst_zero", zero, FLAGS);
        check("rst_parity", parity, 0);

        run_stream(0, 0);
        run_stream(2, 4);
        run_random(1000);

        // Two beats in flight, then asynchronous reset between clock edges.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'h11; b = 8'h22; op = 3'd1;
        @(posedge clk); #1;
        a = 8'h33; b = 8'h0F; op = 3'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("inflight_out_valid", out_valid, 1);
        check("inflight_in_ready", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_in_ready", in_ready, 1);
        check("async_rst_y", y, 8'h00);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", out_valid, 0);
        end
        send_one("post_rst", 8'h12, 8'h21, 3'd1, 8'h33, 1'b0, 1'b0);

        send_one("flag_xor", 8'hA5, 8'hA5, 3'd4, 8'h00, FLAGS, 1'b0);
        send_one("flag_pass", 8'hA5, 8'hA5, 3'd7, 8'hA5, 1'b0, 1'b0);
        send_one("flag_and", 8'h07, 8'h0D, 3'd0, 8'h05, 1'b0, 1'b0);
        send_one("flag_nota", 8'hFE, 8'h00, 3'd6, 8'h01, 1'b0, FLAGS);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
